// File: rtl/score_board_pkg.sv
// Shared types and constants for the scoreboard issue stage.
// Slot geometry, register-file width and the load/store opcodes live here.
package score_board_pkg;

  localparam int XLEN        = 32;
  localparam int OPT_WID     = 7;
  localparam int FUNCT3_WID  = 3;
  localparam int REG_WID     = 5;
  localparam int REG_NUM     = 32;
  localparam int SB_SIZE     = 8;
  localparam int SB_SIZE_WID = 3;
  localparam int ALU_SLOTS   = 4;
  localparam int LS_SLOTS    = SB_SIZE - ALU_SLOTS;

  localparam logic [OPT_WID-1:0] OPT_LOAD  = 7'b0000011;
  localparam logic [OPT_WID-1:0] OPT_STORE = 7'b0100011;

  typedef struct packed {
    logic [OPT_WID-1:0]    opt;
    logic [FUNCT3_WID-1:0] funct;
    logic [REG_WID-1:0]    rs1;
    logic [REG_WID-1:0]    rs2;
    logic [REG_WID-1:0]    rd;
    logic [XLEN-1:0]       imm;
  } sb_ins_t;

  typedef enum logic {
    CLS_ALU = 1'b0,
    CLS_LS  = 1'b1
  } sb_cls_e;

  function automatic sb_cls_e sb_class(
    input logic [OPT_WID-1:0] opt
  );
    if (opt == OPT_LOAD || opt == OPT_STORE)
      return CLS_LS;
    return CLS_ALU;
  endfunction

endpackage

// File: rtl/sb_slot_alloc.sv
// Lowest-free-index priority encoder over one class of scoreboard slots.
// Also reports whether any slot is free and how many are free.
module sb_slot_alloc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] busy_i,
  output logic [W-1:0] idx_o,
  output logic         any_o,
  output logic [W:0]   cnt_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cnt_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        idx_o = W'(i);
        any_o = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      cnt_o = cnt_o + {{W{1'b0}}, ~busy_i[i]};
    end
  end

endmodule

// File: rtl/score_board.sv
// In-order scoreboard: one head register, per-class slot table, and a
// per-register pending mask; issues to ALU / LS and retires on writeback.
module score_board
  import score_board_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ib_valid,
  input  logic [OPT_WID-1:0]     ib_opt,
  input  logic [FUNCT3_WID-1:0]  ib_funct,
  input  logic [REG_WID-1:0]     ib_rs1,
  input  logic [REG_WID-1:0]     ib_rs2,
  input  logic [REG_WID-1:0]     ib_rd,
  input  logic [XLEN-1:0]        ib_imm,
  output logic                   ib_vacant_ALU,
  output logic                   ib_vacant_LS,
  output logic                   alu_valid,
  input  logic                   alu_ready,
  output logic [OPT_WID-1:0]     alu_opt,
  output logic [FUNCT3_WID-1:0]  alu_funct,
  output logic [REG_WID-1:0]     alu_rs1,
  output logic [REG_WID-1:0]     alu_rs2,
  output logic [REG_WID-1:0]     alu_rd,
  output logic [XLEN-1:0]        alu_imm,
  output logic [SB_SIZE_WID-1:0] alu_pos,
  output logic                   ls_valid,
  input  logic                   ls_ready,
  output logic [OPT_WID-1:0]     ls_opt,
  output logic [FUNCT3_WID-1:0]  ls_funct,
  output logic [REG_WID-1:0]     ls_rs1,
  output logic [REG_WID-1:0]     ls_rs2,
  output logic [REG_WID-1:0]     ls_rd,
  output logic [XLEN-1:0]        ls_imm,
  output logic [SB_SIZE_WID-1:0] ls_pos,
  input  logic                   wb_valid,
  input  logic [SB_SIZE_WID-1:0] wb_pos,
  input  logic [REG_WID-1:0]     wb_rd
);

  localparam int AW = $clog2(ALU_SLOTS);
  localparam int LW = $clog2(LS_SLOTS);

  sb_ins_t              head_q, head_d;
  logic                 hv_q, hv_d;
  logic [SB_SIZE-1:0]   busy_q, busy_d;
  logic [REG_WID-1:0]   rd_q [SB_SIZE];
  logic [REG_WID-1:0]   rd_d [SB_SIZE];
  logic [REG_NUM-1:0]   pend_q, pend_d;

  sb_ins_t              ib;
  sb_cls_e              head_cls;
  logic                 haz_ok;
  logic [AW-1:0]        alu_idx;
  logic                 alu_any;
  logic [AW:0]          alu_cnt;
  logic [LW-1:0]        ls_idx;
  logic                 ls_any;
  logic [LW:0]          ls_cnt;
  logic                 fire_alu, fire_ls, fire;
  logic [SB_SIZE_WID-1:0] fire_pos;
  logic                 room, alu_left, ls_left;
  logic                 accept;
  sb_ins_t              alu_pl, ls_pl;

  assign ib = {ib_opt, ib_funct, ib_rs1, ib_rs2, ib_rd, ib_imm};

  assign head_cls = sb_class(head_q.opt);

  // Register 0 is never set in pend_q, so no explicit x0 guard is needed here.
  assign haz_ok = !pend_q[head_q.rs1] &&
                  !pend_q[head_q.rs2] &&
                  !pend_q[head_q.rd];

  sb_slot_alloc #(
    .N (ALU_SLOTS),
    .W (AW)
  ) u_alloc_alu (
    .busy_i (busy_q[ALU_SLOTS-1:0]),
    .idx_o  (alu_idx),
    .any_o  (alu_any),
    .cnt_o  (alu_cnt)
  );

  sb_slot_alloc #(
    .N (LS_SLOTS),
    .W (LW)
  ) u_alloc_ls (
    .busy_i (busy_q[SB_SIZE-1:ALU_SLOTS]),
    .idx_o  (ls_idx),
    .any_o  (ls_any),
    .cnt_o  (ls_cnt)
  );

  assign alu_valid = hv_q && head_cls == CLS_ALU && haz_ok && alu_any;
  assign ls_valid  = hv_q && head_cls == CLS_LS  && haz_ok && ls_any;

  assign fire_alu = alu_valid && alu_ready;
  assign fire_ls  = ls_valid  && ls_ready;
  assign fire     = fire_alu || fire_ls;

  // Payloads are zeroed while their port is idle so reset shows all-zero.
  assign alu_pl  = alu_valid ? head_q : '0;
  assign ls_pl   = ls_valid  ? head_q : '0;
  assign alu_pos = alu_valid ? SB_SIZE_WID'(alu_idx) : '0;
  assign ls_pos  = ls_valid  ?
                   SB_SIZE_WID'(ALU_SLOTS) + SB_SIZE_WID'(ls_idx) : '0;

  assign {alu_opt, alu_funct, alu_rs1, alu_rs2, alu_rd, alu_imm} = alu_pl;
  assign {ls_opt, ls_funct, ls_rs1, ls_rs2, ls_rd, ls_imm} = ls_pl;

  assign fire_pos = fire_ls ? ls_pos : alu_pos;

  assign room     = !hv_q || fire;
  assign alu_left = fire_alu ? (alu_cnt > {{AW{1'b0}}, 1'b1})
                             : (alu_cnt != '0);
  assign ls_left  = fire_ls  ? (ls_cnt > {{LW{1'b0}}, 1'b1})
                             : (ls_cnt != '0);

  assign ib_vacant_ALU = room && alu_left;
  assign ib_vacant_LS  = room && ls_left;

  assign accept = ib_valid &&
                  (sb_class(ib_opt) == CLS_LS ? ib_vacant_LS
                                              : ib_vacant_ALU);

  always_comb begin
    hv_d   = hv_q;
    head_d = head_q;
    busy_d = busy_q;
    rd_d   = rd_q;
    pend_d = pend_q;
    if (wb_valid && busy_q[wb_pos]) begin
      busy_d[wb_pos]       = 1'b0;
      pend_d[rd_q[wb_pos]] = 1'b0;
    end
    if (fire) begin
      busy_d[fire_pos] = 1'b1;
      rd_d[fire_pos]   = head_q.rd;
      if (head_q.rd != '0)
        pend_d[head_q.rd] = 1'b1;
      hv_d = 1'b0;
    end
    if (accept) begin
      hv_d   = 1'b1;
      head_d = ib;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hv_q   <= 1'b0;
      head_q <= '0;
      busy_q <= '0;
      rd_q   <= '{default: '0};
      pend_q <= '0;
    end else begin
      hv_q   <= hv_d;
      head_q <= head_d;
      busy_q <= busy_d;
      rd_q   <= rd_d;
      pend_q <= pend_d;
    end
  end

  wb_rd_match: assert property (
    @(posedge clk) disable iff (!rst)
    (wb_valid && busy_q[wb_pos]) |-> (wb_rd == rd_q[wb_pos])
  );

  one_issue: assert property (
    @(posedge clk) disable iff (!rst)
    !(alu_valid && ls_valid)
  );

endmodule

// File: tb/tb_score_board.sv
// Bench for score_board: directed table, corner sequences, random stream
// checked against an in-flight-list reference model.
module tb_score_board;
  import score_board_pkg::*;

  localparam logic [6:0] ALU = 7'h33;
  localparam logic [6:0] LD  = 7'h03;
  localparam logic [6:0] ST  = 7'h23;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ib_valid;
  logic [6:0]  ib_opt;
  logic [2:0]  ib_funct;
  logic [4:0]  ib_rs1, ib_rs2, ib_rd;
  logic [31:0] ib_imm;
  logic        ib_vacant_ALU, ib_vacant_LS;
  logic        alu_valid, alu_ready;
  logic [6:0]  alu_opt;
  logic [2:0]  alu_funct;
  logic [4:0]  alu_rs1, alu_rs2, alu_rd;
  logic [31:0] alu_imm;
  logic [2:0]  alu_pos;
  logic        ls_valid, ls_ready;
  logic [6:0]  ls_opt;
  logic [2:0]  ls_funct;
  logic [4:0]  ls_rs1, ls_rs2, ls_rd;
  logic [31:0] ls_imm;
  logic [2:0]  ls_pos;
  logic        wb_valid;
  logic [2:0]  wb_pos;
  logic [4:0]  wb_rd;

  always #5 clk = ~clk;

  score_board dut (
    .clk(clk), .rst(rst),
    .ib_valid(ib_valid), .ib_opt(ib_opt), .ib_funct(ib_funct),
    .ib_rs1(ib_rs1), .ib_rs2(ib_rs2), .ib_rd(ib_rd), .ib_imm(ib_imm),
    .ib_vacant_ALU(ib_vacant_ALU), .ib_vacant_LS(ib_vacant_LS),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_opt(alu_opt), .alu_funct(alu_funct), .alu_rs1(alu_rs1),
    .alu_rs2(alu_rs2), .alu_rd(alu_rd), .alu_imm(alu_imm),
    .alu_pos(alu_pos),
    .ls_valid(ls_valid), .ls_ready(ls_ready),
    .ls_opt(ls_opt), .ls_funct(ls_funct), .ls_rs1(ls_rs1),
    .ls_rs2(ls_rs2), .ls_rd(ls_rd), .ls_imm(ls_imm), .ls_pos(ls_pos),
    .wb_valid(wb_valid), .wb_pos(wb_pos), .wb_rd(wb_rd)
  );

  typedef struct {
    bit          ibv;
    logic [6:0]  opt;
    logic [2:0]  funct;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    bit          ar, lr, wbv;
    logic [2:0]  wbpos;
    logic [4:0]  wbrd;
  } stim_t;

  typedef struct {
    stim_t s;
    bit av; int apos; bit lv; int lpos; bit va; bit vl;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // reference model: head + map of in-flight slot -> destination register
  bit      m_hv;
  sb_ins_t m_head;
  int      m_fl[int];

  // values sampled in the most recent cycle (before its rising edge)
  bit          s_av, s_lv, s_va, s_vl;
  int          s_apos, s_lpos;
  logic [63:0] s_lpl;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic stim_t mk(bit ibv, logic [6:0] opt,
                               int rs1, int rs2, int rd,
                               bit ar, bit lr, bit wbv,
                               int wbpos, int wbrd);
    stim_t s;
    s.ibv = ibv; s.opt = opt;
    s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
    s.funct = 3'(rd + 1);
    s.imm = 32'h1000 + 32'(rd * 7 + rs1);
    s.ar = ar; s.lr = lr; s.wbv = wbv;
    s.wbpos = 3'(wbpos); s.wbrd = 5'(wbrd);
    return s;
  endfunction

  function automatic bit m_is_ls(logic [6:0] opt);
    return opt == LD || opt == ST;
  endfunction

  function automatic bit m_pend(int r);
    if (r == 0) return 1'b0;
    foreach (m_fl[p]) if (m_fl[p] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_free(int lo, int hi, output int first);
    int cnt = 0;
    first = 0;
    for (int p = hi - 1; p >= lo; p--)
      if (!m_fl.exists(p)) begin cnt++; first = p; end
    return cnt;
  endfunction

  task automatic drive(stim_t s);
    ib_valid = s.ibv; ib_opt = s.opt; ib_funct = s.funct;
    ib_rs1 = s.rs1; ib_rs2 = s.rs2; ib_rd = s.rd; ib_imm = s.imm;
    alu_ready = s.ar; ls_ready = s.lr;
    wb_valid = s.wbv; wb_pos = s.wbpos; wb_rd = s.wbrd;
  endtask

  task automatic cyc(stim_t s);
    bit hz, is_ls, e_av, e_lv, fa, fl, e_va, e_vl, acc;
    int af, lf, afirst, lfirst;
    logic [63:0] e_pl;
    @(negedge clk);
    drive(s);
    #1;
    is_ls = m_is_ls(m_head.opt);
    hz = !m_pend(m_head.rs1) && !m_pend(m_head.rs2) && !m_pend(m_head.rd);
    af = m_free(0, ALU_SLOTS, afirst);
    lf = m_free(ALU_SLOTS, SB_SIZE, lfirst);
    e_av = m_hv && !is_ls && hz && af > 0;
    e_lv = m_hv && is_ls && hz && lf > 0;
    fa = e_av && s.ar;
    fl = e_lv && s.lr;
    e_va = (!m_hv || fa || fl) && (af - int'(fa)) > 0;
    e_vl = (!m_hv || fa || fl) && (lf - int'(fl)) > 0;
    e_pl = 64'(m_head);
    chk("alu_valid", 64'(alu_valid), 64'(e_av));
    chk("alu_pos", 64'(alu_pos), e_av ? 64'(afirst) : 64'd0);
    chk("alu_payload",
        64'({alu_opt, alu_funct, alu_rs1, alu_rs2, alu_rd, alu_imm}),
        e_av ? e_pl : 64'd0);
    chk("ls_valid", 64'(ls_valid), 64'(e_lv));
    chk("ls_pos", 64'(ls_pos), e_lv ? 64'(lfirst) : 64'd0);
    chk("ls_payload",
        64'({ls_opt, ls_funct, ls_rs1, ls_rs2, ls_rd, ls_imm}),
        e_lv ? e_pl : 64'd0);
    chk("vacant_alu", 64'(ib_vacant_ALU), 64'(e_va));
    chk("vacant_ls", 64'(ib_vacant_LS), 64'(e_vl));
    s_av = alu_valid; s_lv = ls_valid;
    s_va = ib_vacant_ALU; s_vl = ib_vacant_LS;
    s_apos = int'(alu_pos); s_lpos = int'(ls_pos);
    s_lpl = 64'({ls_opt, ls_funct, ls_rs1, ls_rs2, ls_rd, ls_imm});
    @(posedge clk);
    if (s.wbv && m_fl.exists(int'(s.wbpos))) m_fl.delete(int'(s.wbpos));
    if (fa) m_fl[afirst] = int'(m_head.rd);
    if (fl) m_fl[lfirst] = int'(m_head.rd);
    acc = s.ibv && (m_is_ls(s.opt) ? e_vl : e_va);
    if (acc) begin
      m_hv = 1'b1;
      m_head = {s.opt, s.funct, s.rs1, s.rs2, s.rd, s.imm};
    end else if (fa || fl) begin
      m_hv = 1'b0;
    end
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_alu_valid"}, 64'(alu_valid), 64'd0);
    chk({tag, "_ls_valid"}, 64'(ls_valid), 64'd0);
    chk({tag, "_vac_alu"}, 64'(ib_vacant_ALU), 64'd1);
    chk({tag, "_vac_ls"}, 64'(ib_vacant_LS), 64'd1);
    chk({tag, "_payload"},
        64'({alu_opt, alu_rd, alu_imm, alu_pos, ls_opt, ls_rd, ls_imm,
             ls_pos}), 64'd0);
  endtask

  task automatic do_reset(string tag);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_outs(tag);
    m_hv = 1'b0; m_head = '0; m_fl.delete();
    drive(mk(0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t tbl[12];

  initial begin
    stim_t s, held;
    int keys[$];
    m_hv = 1'b0; m_head = '0;
    drive(mk(0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk_reset_outs("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    tbl[0]  = '{mk(1, ALU, 2, 3, 1, 1, 1, 0, 0, 0), 0, 0, 0, 0, 1, 1};
    tbl[1]  = '{mk(1, ALU, 5, 6, 4, 1, 1, 0, 0, 0), 1, 0, 0, 0, 1, 1};
    tbl[2]  = '{mk(1, ALU, 1, 2, 7, 1, 1, 0, 0, 0), 1, 1, 0, 0, 1, 1};
    tbl[3]  = '{mk(1, ALU, 2, 3, 9, 1, 1, 0, 0, 0), 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{mk(0, ALU, 0, 0, 0, 1, 1, 1, 0, 1), 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{mk(1, ALU, 2, 3, 0, 1, 1, 0, 0, 0), 1, 0, 0, 0, 1, 1};
    tbl[6]  = '{mk(1, ALU, 0, 0, 8, 1, 1, 0, 0, 0), 1, 2, 0, 0, 1, 1};
    tbl[7]  = '{mk(0, ALU, 0, 0, 0, 1, 1, 0, 0, 0), 1, 3, 0, 0, 0, 1};
    tbl[8]  = '{mk(1, LD, 11, 0, 10, 1, 1, 0, 0, 0), 0, 0, 0, 0, 0, 1};
    tbl[9]  = '{mk(0, ALU, 0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 1, 4, 0, 0};
    tbl[10] = '{mk(0, ALU, 0, 0, 0, 1, 1, 0, 0, 0), 0, 0, 1, 4, 0, 1};
    tbl[11] = '{mk(1, ALU, 0, 0, 0, 1, 1, 1, 5, 0), 0, 0, 0, 0, 0, 1};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].s);
      chk($sformatf("tbl%0d_av", i), 64'(s_av), 64'(tbl[i].av));
      chk($sformatf("tbl%0d_apos", i), 64'(s_apos), 64'(tbl[i].apos));
      chk($sformatf("tbl%0d_lv", i), 64'(s_lv), 64'(tbl[i].lv));
      chk($sformatf("tbl%0d_lpos", i), 64'(s_lpos), 64'(tbl[i].lpos));
      chk($sformatf("tbl%0d_va", i), 64'(s_va), 64'(tbl[i].va));
      chk($sformatf("tbl%0d_vl", i), 64'(s_vl), 64'(tbl[i].vl));
    end

    do_reset("rst1");

    // fill all four LS slots, then free pos 6
    cyc(mk(1, LD, 1, 0, 10, 1, 1, 0, 0, 0));
    cyc(mk(1, LD, 1, 0, 11, 1, 1, 0, 0, 0));
    cyc(mk(1, ST, 1, 2, 0, 1, 1, 0, 0, 0));
    cyc(mk(1, LD, 1, 0, 12, 1, 1, 0, 0, 0));
    cyc(mk(0, LD, 0, 0, 0, 1, 1, 0, 0, 0));
    chk("lsfull_fire_vl", 64'(s_vl), 64'd0);
    cyc(mk(1, LD, 2, 0, 13, 1, 1, 0, 0, 0));
    chk("lsfull_vl", 64'(s_vl), 64'd0);
    chk("lsfull_va", 64'(s_va), 64'd1);
    cyc(mk(0, LD, 0, 0, 0, 1, 1, 1, 6, 0));
    chk("lsfull_wb_vl", 64'(s_vl), 64'd0);
    cyc(mk(1, LD, 2, 0, 13, 1, 1, 0, 0, 0));
    chk("lsfree_vl", 64'(s_vl), 64'd1);

    // ready stall on the LS port, with a spurious writeback mid-stall
    cyc(mk(0, LD, 0, 0, 0, 1, 0, 0, 0, 0));
    chk("stall_lv", 64'(s_lv), 64'd1);
    chk("stall_lpos", 64'(s_lpos), 64'd6);
    held.ibv = 0;
    begin
      logic [63:0] pl0;
      pl0 = s_lpl;
      for (int i = 0; i < 5; i++) begin
        cyc(mk(0, LD, 0, 0, 0, 1, 0, i == 2, 3, 9));
        chk($sformatf("stall%0d_lpos", i), 64'(s_lpos), 64'd6);
        chk($sformatf("stall%0d_pl", i), s_lpl, pl0);
      end
    end
    cyc(mk(1, ALU, 10, 0, 1, 1, 1, 0, 0, 0));
    chk("stall_fire_lpos", 64'(s_lpos), 64'd6);
    cyc(mk(0, ALU, 0, 0, 0, 1, 1, 0, 0, 0));
    chk("dep_stall_av", 64'(s_av), 64'd0);

    // asynchronous reset with slots busy and a stalled head
    do_reset("rst2");
    cyc(mk(1, ALU, 10, 0, 2, 1, 1, 0, 0, 0));
    cyc(mk(1, LD, 12, 0, 5, 1, 1, 0, 0, 0));
    chk("post_rst_av", 64'(s_av), 64'd1);
    chk("post_rst_apos", 64'(s_apos), 64'd0);
    cyc(mk(0, ALU, 0, 0, 0, 1, 1, 0, 0, 0));
    chk("post_rst_lpos", 64'(s_lpos), 64'd4);

    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom % 3);
      s = mk(($urandom % 10) < 7, r == 0 ? LD : (r == 1 ? ST : ALU),
             int'($urandom % 8), int'($urandom % 8), int'($urandom % 8),
             ($urandom % 4) != 0, ($urandom % 4) != 0, 0, 0, 0);
      s.funct = 3'($urandom);
      s.imm = $urandom;
      keys.delete();
      foreach (m_fl[p]) keys.push_back(p);
      if (keys.size() > 0 && ($urandom % 100) < 40) begin
        int k;
        k = keys[$urandom % keys.size()];
        s.wbv = 1'b1; s.wbpos = 3'(k); s.wbrd = 5'(m_fl[k]);
      end else if (($urandom % 100) < 5) begin
        s.wbv = 1'b1; s.wbpos = 3'($urandom); s.wbrd = 5'($urandom);
        if (m_fl.exists(int'(s.wbpos))) s.wbrd = 5'(m_fl[int'(s.wbpos)]);
      end
      cyc(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
